// File: rtl/bcd_conv_arbiter.sv
// Round-robin arbiter that shares one sequential binary-to-BCD converter among N
// requesters, returning the tagged, signed BCD result on a shared result bus.
module bcd_conv_arbiter #(
  parameter int N       = 4,
  parameter int TIMEOUT = 32,
  parameter int IDW     = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      req_i,
  input  logic [N*8-1:0]    data_i,
  output logic [N-1:0]      ack_o,
  output logic              conv_start_o,
  output logic [7:0]        conv_data_o,
  input  logic              conv_done_i,
  input  logic [11:0]       conv_bcd_i,
  output logic              res_valid_o,
  output logic [IDW-1:0]    res_id_o,
  output logic [11:0]       res_bcd_o,
  output logic              res_sign_o,
  output logic              res_err_o,
  output logic              busy_o,
  output logic [1:0]        state_o
);

  // Handshake: a requester holds req_i/data_i until its one-cycle ack_o pulse;
  // data_i is sampled only on the IDLE edge that issues the grant.
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_LAUNCH  = 2'd1;
  localparam logic [1:0] S_WAIT    = 2'd2;
  localparam logic [1:0] S_DELIVER = 2'd3;

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic [1:0]     state;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] grant;
  logic           sign;
  logic [7:0]     mag;
  logic [CW-1:0]  cnt;

  logic           found;
  logic [IDW-1:0] next_grant;
  logic [7:0]     next_data;
  logic [IDW-1:0] idx;

  // First requester at or after ptr, wrapping modulo N.
  always_comb begin
    found      = 1'b0;
    next_grant = '0;
    next_data  = '0;
    idx        = '0;
    for (int i = 0; i < N; i++) begin
      idx = IDW'((int'(ptr) + i) % N);
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        next_grant = idx;
        next_data  = data_i[{idx, 3'b000} +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      ptr        <= '0;
      grant      <= '0;
      sign       <= 1'b0;
      mag        <= '0;
      cnt        <= '0;
      res_id_o   <= '0;
      res_bcd_o  <= '0;
      res_sign_o <= 1'b0;
      res_err_o  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (found) begin
            grant <= next_grant;
            sign  <= next_data[7];
            // -128 wraps to 8'h80, which reads as 128 unsigned.
            mag   <= next_data[7] ? (~next_data + 8'd1) : next_data;
            state <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          cnt   <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (conv_done_i) begin
            res_bcd_o  <= conv_bcd_i;
            res_err_o  <= 1'b0;
            res_sign_o <= sign;
            res_id_o   <= grant;
            state      <= S_DELIVER;
          end else if (cnt == CNT_LAST) begin
            res_bcd_o  <= 12'h000;
            res_err_o  <= 1'b1;
            res_sign_o <= sign;
            res_id_o   <= grant;
            state      <= S_DELIVER;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_DELIVER: begin
          ptr   <= (grant == IDW'(N - 1)) ? '0 : grant + IDW'(1);
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign ack_o        = (state == S_LAUNCH) ? ({{(N-1){1'b0}}, 1'b1} << grant) : '0;
  assign conv_start_o = (state == S_LAUNCH);
  assign conv_data_o  = mag;
  assign res_valid_o  = (state == S_DELIVER);
  assign busy_o       = (state != S_IDLE);
  assign state_o      = state;

endmodule

// File: doc/bcd_conv_arbiter.md
Name: bcd_conv_arbiter

Overview:
Shares one sequential binary-to-BCD (double-dabble) converter among N requesters, using round-robin arbitration. Each requester offers an 8-bit two's-complement value. The arbiter captures the sign, drives the magnitude into the converter with a start pulse, and waits for done or a timeout. It then returns the tagged BCD result to all requesters on a shared result bus, which the per-digit display decoders can consume.

Parameters:
N, 4, number of requesters (2..8)
TIMEOUT, 32, max cycles in WAIT before abort (>=2)
IDW, $clog2(N), width of requester ID

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-low reset
req_i  in  N  per-requester request level
data_i  in  N*8  requester k value at [8k+7:8k], two's complement
ack_o  out  N  one-hot 1-cycle pulse: request k accepted
conv_start_o  out  1  1-cycle start pulse to converter
conv_data_o  out  8  unsigned magnitude to converter
conv_done_i  in  1  converter result valid (1-cycle pulse)
conv_bcd_i  in  12  converter result {cent,dec,uni}
res_valid_o  out  1  1-cycle result strobe
res_id_o  out  IDW  requester the result belongs to
res_bcd_o  out  12  {cent,dec,uni} BCD digits
res_sign_o  out  1  1 = negative input
res_err_o  out  1  1 = converter timed out
busy_o  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst=0, async): state IDLE, rr pointer 0, timeout counter 0. Every output 0, including conv_data_o, res_* and ack_o.
- FSM states: IDLE, LAUNCH, WAIT, DELIVER.
- IDLE, when req_i != 0 at a rising edge:
  - grant = first index with req high, searching from ptr upward and wrapping modulo N.
  - Register grant, sign = data[7], and mag = data[7] ? (~data+1) : data, all 8-bit unsigned; -128 gives 128.
  - Go to LAUNCH. With no request, stay in IDLE.
- LAUNCH (exactly 1 cycle):
  - ack_o[grant]=1, conv_start_o=1, conv_data_o=mag.
  - Go to WAIT and clear the counter.
  - conv_done_i is ignored in this state.
- WAIT:
  - conv_data_o is held at mag.
  - If conv_done_i=1, capture conv_bcd_i, set err=0, go to DELIVER.
  - Else if counter == TIMEOUT-1, set bcd=12'h000, err=1, go to DELIVER.
  - Else increment the counter.
  - If done arrives on the timeout cycle, done wins.
- DELIVER (1 cycle):
  - res_valid_o=1 with res_id_o=grant and res_bcd_o, res_sign_o, res_err_o as captured.
  - ptr = (grant+1) mod N. Go to IDLE.
- res_id/bcd/sign/err hold their values after the strobe until the next DELIVER.
- Requester protocol: hold req_i and data_i stable until ack_o, then deassert req_i within 2 cycles. A req dropped before being sampled in IDLE is not served. data_i is sampled only at the IDLE grant edge.
- Minimum turnaround: 4 cycles per conversion plus the converter latency. A new grant is issued no earlier than the cycle after DELIVER.
- Fairness: with all N requesting continuously, grants rotate 0,1,…,N-1,0.
- A conv_done_i arriving in IDLE or DELIVER is ignored and discarded.
- Reset asserted mid-operation aborts the transaction: no res_valid_o, no ack_o, and ptr returns to 0.

Test Plan:
- Single requester: req_i=4'b0100, data=8'd123, converter done 10 cycles after start → ack_o=4'b0100 in LAUNCH; conv_data_o=123; res_valid_o one cycle, res_id=2, res_bcd=12'h123, sign=0, err=0.
- Negative extreme: data=8'h80 → conv_data_o=8'd128, res_sign_o=1, res_bcd=12'h128. Repeat with data=8'hFF → mag 1, bcd 12'h001, sign 1.
- Round robin: all four requesters held high, each releasing one cycle after its ack → ack order 0,1,2,3,0. Each res_id_o matches its preceding ack.
- Timeout: converter never asserts done, TIMEOUT=32 → res_valid_o 33 cycles after LAUNCH with res_err_o=1, res_bcd=0. A done arriving exactly on the final WAIT cycle → err=0.
- Reset mid-WAIT: rst low for 1 cycle while busy → every output 0 immediately. A subsequent done is ignored, and the next grant starts from index 0.
- Idle noise: conv_done_i pulsed while in IDLE → no res_valid_o, state remains IDLE.
